// File: rtl/debug_request_scheduler.sv
// rtl/debug_request_scheduler.sv - walks debug control units in ID order and forwards their frames to the TX FIFO
module debug_request_scheduler #(
  parameter int          N_CTRL           = 4,
  parameter int          NB_CONTROL_FRAME = 32,
  parameter int          NB_TIMEOUT       = 4,
  parameter int          TIMEOUT          = 8,
  parameter logic [5:0]  IDLE_ID          = 6'h3F
) (
  input  logic                               i_clock,
  input  logic                               i_reset,
  input  logic                               i_start,
  input  logic [N_CTRL-1:0]                  i_writing,
  input  logic [N_CTRL*NB_CONTROL_FRAME-1:0] i_frames,
  input  logic                               i_fifo_full,
  output logic [5:0]                         o_request_select,
  output logic [NB_CONTROL_FRAME-1:0]        o_frame,
  output logic                               o_frame_valid,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_timeout_err,
  output logic                               o_overflow_err
);

  localparam int NB_IDX = (N_CTRL > 1) ? $clog2(N_CTRL) : 1;
  localparam logic [NB_IDX-1:0]     LAST_IDX   = NB_IDX'(N_CTRL - 1);
  localparam logic [NB_TIMEOUT-1:0] TIMER_LAST = NB_TIMEOUT'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WAIT, STREAM, GAP, DONE} state_t;

  state_t                  state;
  logic [NB_IDX-1:0]       idx;
  logic [NB_TIMEOUT-1:0]   timer;
  logic                    sel_writing;
  logic [NB_CONTROL_FRAME-1:0] sel_frame;

  assign sel_writing = i_writing[idx];
  assign sel_frame   = i_frames[int'(idx)*NB_CONTROL_FRAME +: NB_CONTROL_FRAME];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state            <= IDLE;
      idx              <= '0;
      timer            <= '0;
      o_request_select <= IDLE_ID;
      o_frame          <= '0;
      o_frame_valid    <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_timeout_err    <= 1'b0;
      o_overflow_err   <= 1'b0;
    end else begin
      o_done        <= 1'b0;
      o_frame_valid <= 1'b0;

      // A frame offered while the FIFO is full is lost, not retried.
      if ((state == WAIT || state == STREAM) && sel_writing) begin
        if (!i_fifo_full) begin
          o_frame       <= sel_frame;
          o_frame_valid <= 1'b1;
        end else begin
          o_overflow_err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (i_start) begin
            state            <= WAIT;
            idx              <= '0;
            timer            <= '0;
            o_request_select <= 6'd0;
            o_busy           <= 1'b1;
            o_timeout_err    <= 1'b0;
            o_overflow_err   <= 1'b0;
          end
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (sel_writing) begin
            state <= STREAM;
          end else if (timer == TIMER_LAST) begin
            o_timeout_err    <= 1'b1;
            state            <= GAP;
            o_request_select <= IDLE_ID;
          end
        end
        STREAM: begin
          if (!sel_writing) begin
            state            <= GAP;
            o_request_select <= IDLE_ID;
          end
        end
        GAP: begin
          timer <= '0;
          if (idx == LAST_IDX) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else begin
            idx              <= idx + 1'b1;
            state            <= WAIT;
            o_request_select <= 6'(idx + 1'b1);
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state            <= IDLE;
          o_busy           <= 1'b0;
          o_request_select <= IDLE_ID;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_request_scheduler.sv
// tb/tb_debug_request_scheduler.sv - scoreboard bench for debug_request_scheduler with two modelled units
module tb_debug_request_scheduler;

  localparam int N  = 2;
  localparam int NB = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [N-1:0]    writing;
  logic [N*NB-1:0] frames;
  logic            full;
  logic [5:0]      sel;
  logic [NB-1:0]   frame;
  logic            frame_valid;
  logic            busy;
  logic            done;
  logic            timeout_err;
  logic            overflow_err;

  debug_request_scheduler #(
    .N_CTRL(N), .NB_CONTROL_FRAME(NB), .NB_TIMEOUT(4), .TIMEOUT(TO), .IDLE_ID(6'h3F)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_writing(writing),
    .i_frames(frames), .i_fifo_full(full), .o_request_select(sel),
    .o_frame(frame), .o_frame_valid(frame_valid), .o_busy(busy), .o_done(done),
    .o_timeout_err(timeout_err), .o_overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [NB-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   sel_runs[$];
  int   cyc = 0;
  int   nfr[N];
  int   dly[N];
  int   full_idx[N];

  function automatic logic [NB-1:0] fv(input int u, input int k);
    return 32'hC0DE_0000 + 32'(u * 256 + k);
  endfunction

  // Units answer only while selected; unselected writing bits are randomised.
  task automatic run_sweep(input bit pulse, input bit mid_start, input bit reset_mid,
                           input bit hold_end, input bit exp_to, input bit exp_ov);
    int   sent[N];
    int   seen[N];
    int   sel1_cnt;
    int   done_cnt;
    bit   fin;
    exp_t e;
    sb.delete();
    sel_runs.delete();
    sel1_cnt = 0;
    done_cnt = 0;
    fin = 1'b0;
    for (int u = 0; u < N; u++) begin
      sent[u] = 0;
      seen[u] = 0;
    end
    if (pulse) start = 1'b1;
    for (int b = 0; b < 200 && !fin; b++) begin
      @(negedge clk);
      cyc++;
      if (b == 0) begin
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("timeout_cleared", timeout_err, 0);
        check("overflow_cleared", overflow_err, 0);
      end
      if (sel_runs.size() == 0 || sel_runs[$] != int'(sel)) sel_runs.push_back(int'(sel));
      if (sel == 6'd1) sel1_cnt++;
      if (frame_valid) begin
        if (sb.size() == 0) begin
          check("extra_frame", frame_valid, 0);
        end else begin
          e = sb.pop_front();
          check("frame", frame, e.data);
          check("latency", cyc, e.cyc + 1);
        end
        if (reset_mid) begin
          rst = 1'b1;
          writing = '0;
          @(negedge clk);
          cyc++;
          check("rst_sel", sel, 6'h3F);
          check("rst_valid", frame_valid, 0);
          check("rst_busy", busy, 0);
          check("rst_done", done, 0);
          rst = 1'b0;
          @(negedge clk);
          cyc++;
          check("rst_no_done", done, 0);
          sb.delete();
          return;
        end
      end
      if (done) begin
        done_cnt++;
        fin = 1'b1;
        if (hold_end) start = 1'b1;
      end
      if (mid_start && b == 3) start = 1'b1;
      if (mid_start && b == 5) start = 1'b0;
      writing = N'($urandom);
      frames  = {$urandom, $urandom};
      full    = 1'b0;
      for (int u = 0; u < N; u++) begin
        if (int'(sel) == u) begin
          writing[u] = 1'b0;
          if (seen[u] >= dly[u] && sent[u] < nfr[u]) begin
            writing[u] = 1'b1;
            frames[u*NB +: NB] = fv(u, sent[u]);
            full = (sent[u] == full_idx[u]);
            if (!full) sb.push_back('{fv(u, sent[u]), cyc});
            sent[u]++;
          end else begin
            seen[u]++;
          end
        end
      end
    end
    check("done_seen", fin, 1);
    @(negedge clk);
    cyc++;
    writing = '0;
    check("done_single", done, 0);
    check("busy_after", busy, 0);
    check("done_count", done_cnt, 1);
    check("all_frames_out", sb.size(), 0);
    check("timeout_err", timeout_err, exp_to);
    check("overflow_err", overflow_err, exp_ov);
    check("sel1_cycles", sel1_cnt, (nfr[1] > 0) ? dly[1] + nfr[1] + 1 : TO);
    check("sel_runs", sel_runs.size(), 4);
    if (sel_runs.size() == 4) begin
      check("sel_run0", sel_runs[0], 0);
      check("sel_run1", sel_runs[1], 6'h3F);
      check("sel_run2", sel_runs[2], 1);
      check("sel_run3", sel_runs[3], 6'h3F);
    end
  endtask

  task automatic cfg(input int n0, input int d0, input int f0,
                     input int n1, input int d1, input int f1);
    nfr[0] = n0; dly[0] = d0; full_idx[0] = f0;
    nfr[1] = n1; dly[1] = d1; full_idx[1] = f1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    writing = '0;
    frames = '0;
    full = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_sel", sel, 6'h3F);
    check("reset_busy", busy, 0);
    check("reset_valid", frame_valid, 0);
    check("reset_done", done, 0);
    check("reset_tmo", timeout_err, 0);
    check("reset_ovf", overflow_err, 0);
    check("reset_frame", frame, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_sel", sel, 6'h3F);

    cfg(1, 0, -1, 3, 2, -1);
    run_sweep(1, 0, 0, 0, 0, 0);

    cfg(2, 1, -1, 0, 0, -1);
    run_sweep(1, 0, 0, 0, 1, 0);
    cfg(1, 3, -1, 2, 0, -1);
    run_sweep(1, 0, 0, 0, 0, 0);

    cfg(3, 0, 1, 1, 0, -1);
    run_sweep(1, 0, 0, 0, 0, 1);

    cfg(2, 0, -1, 3, 1, -1);
    run_sweep(1, 1, 0, 1, 0, 0);
    check("held_start_idle", busy, 0);
    cfg(1, 2, -1, 1, 7, -1);
    run_sweep(0, 0, 0, 0, 0, 0);

    cfg(3, 0, -1, 1, 0, -1);
    run_sweep(1, 0, 1, 0, 0, 0);
    check("post_rst_idle_sel", sel, 6'h3F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
